// File: rtl/axi_rd_slave.sv
// AXI4-style read-channel responder: AR request in, R beats out, one beat per
// single-port memory fetch (1-cycle read latency) with a gap cycle between beats.
module axi_rd_slave #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              ARVALID,
  output logic              ARREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [LEN_W-1:0]  ARLEN,
  input  logic [1:0]        ARBURST,
  input  logic [2:0]        ARPROT,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] STRIDE     = ADDR_W'(DATA_W / 8);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(STRIDE - ADDR_W'(1));

  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt;
  logic [1:0]        burst_q;

  logic              ar_hs;
  logic              r_hs;
  logic              err_q;
  logic [ADDR_W-1:0] ar_addr_al;
  logic [ADDR_W-1:0] next_addr;

  logic unused_prot;
  assign unused_prot = ^ARPROT;

  assign ar_hs      = (state == IDLE) && ARVALID && ARREADY;
  assign r_hs       = (state == SEND) && RVALID && RREADY;
  assign err_q      = burst_q[1];
  assign ar_addr_al = ARADDR & ALIGN_MASK;
  // FIXED repeats the start word; INCR wraps naturally at 2^ADDR_W
  assign next_addr  = (burst_q == 2'b00) ? addr_q : addr_q + STRIDE;

  // Fetch is issued in the handshake cycle so data lands during FETCH
  always_comb begin
    mem_en   = 1'b0;
    mem_addr = addr_q;
    if (ar_hs) begin
      mem_en   = ~ARBURST[1];
      mem_addr = ar_addr_al;
    end else if (r_hs && !RLAST) begin
      mem_en   = ~err_q;
      mem_addr = next_addr;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state   <= IDLE;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RLAST   <= 1'b0;
      RRESP   <= 2'b00;
      RDATA   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt     <= '0;
      burst_q <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          ARREADY <= 1'b1;
          if (ar_hs) begin
            addr_q  <= ar_addr_al;
            len_q   <= ARLEN;
            burst_q <= ARBURST;
            cnt     <= '0;
            ARREADY <= 1'b0;
            state   <= FETCH;
          end
        end
        FETCH: begin
          RDATA  <= err_q ? '0 : mem_rdata;
          RRESP  <= err_q ? 2'b10 : 2'b00;
          RLAST  <= (cnt == len_q);
          RVALID <= 1'b1;
          state  <= SEND;
        end
        SEND: begin
          if (RREADY) begin
            RVALID <= 1'b0;
            if (RLAST) begin
              RLAST   <= 1'b0;
              ARREADY <= 1'b1;
              state   <= IDLE;
            end else begin
              cnt    <= cnt + 1'b1;
              addr_q <= next_addr;
              state  <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_slave.sv
// Bench for axi_rd_slave: table of bursts plus reset and back-to-back sequences,
// with an address/beat scoreboard fed from the stimulus side.
module tb_axi_rd_slave;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [1:0]  ARBURST;
  logic [2:0]  ARPROT;
  logic        RVALID;
  logic        RREADY;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [63:0] mem_rdata;

  axi_rd_slave #(.ADDR_W(32), .DATA_W(64), .LEN_W(8)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN),
    .ARBURST(ARBURST), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    bit          stall;
    int          exp_beats;
    int          exp_mem;
    logic [31:0] exp_last;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t       exp_beats[$];
  logic [31:0] exp_addrs[$];
  vec_t        vecs[7];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hs_count = 0;
  int mem_cnt  = 0;
  int rv_due   = -10;
  int last_hs_cyc = 0;
  logic [31:0] last_mem_addr = '0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic        prev_last;
  beat_t       eb;
  logic [31:0] ea;

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0008) return 64'h1122_3344_5566_7788;
    return {a ^ 32'hA5A5_0000, ~a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge ACLK) begin
    cyc <= cyc + 1;
    mem_rdata <= mem_en ? mem_word(mem_addr) : 64'hDEAD_BEEF_0BAD_F00D;
  end

  always @(negedge ACLK) begin
    if (!ARESETn) begin
      exp_beats.delete();
      exp_addrs.delete();
      rv_due = -10;
      prev_stall = 1'b0;
    end else begin
      if (mem_en) begin
        mem_cnt++;
        last_mem_addr = mem_addr;
        chk("mem_en_expected", 64'(exp_addrs.size() > 0), 64'd1);
        if (exp_addrs.size() > 0) begin
          ea = exp_addrs.pop_front();
          chk("mem_addr", 64'(mem_addr), 64'(ea));
        end
      end
      if (cyc == rv_due - 1) chk("gap_rvalid_low", 64'(RVALID), 64'd0);
      if (cyc == rv_due)     chk("rvalid_latency", 64'(RVALID), 64'd1);
      if (RVALID && prev_stall) begin
        chk("rdata_stable", RDATA, prev_data);
        chk("rlast_stable", 64'(RLAST), 64'(prev_last));
      end
      if (ARVALID && ARREADY) rv_due = cyc + 2;
      if (RVALID && RREADY) begin
        hs_count++;
        chk("beat_expected", 64'(exp_beats.size() > 0), 64'd1);
        if (exp_beats.size() > 0) begin
          eb = exp_beats.pop_front();
          chk("rdata", RDATA, eb.data);
          chk("rresp", 64'(RRESP), 64'(eb.resp));
          chk("rlast", 64'(RLAST), 64'(eb.last));
        end
        if (!RLAST) rv_due = cyc + 2;
        else last_hs_cyc = cyc;
      end
      prev_stall = RVALID && !RREADY;
      prev_data  = RDATA;
      prev_last  = RLAST;
    end
  end

  task automatic push_expect(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
    logic [31:0] a;
    logic [31:0] ai;
    beat_t b;
    a = addr & 32'hFFFF_FFF8;
    for (int i = 0; i <= int'(len); i++) begin
      ai = (burst == 2'b00) ? a : a + 32'(i * 8);
      b.data = burst[1] ? 64'd0 : mem_word(ai);
      b.resp = burst[1] ? 2'b10 : 2'b00;
      b.last = (i == int'(len));
      exp_beats.push_back(b);
      if (!burst[1]) exp_addrs.push_back(ai);
    end
  endtask

  task automatic drive_ar(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b);
    int c;
    c = 0;
    ARVALID = 1'b1; ARADDR = a; ARLEN = l; ARBURST = b; ARPROT = 3'b010;
    do begin
      @(negedge ACLK);
      c++;
    end while (!ARREADY && c < 50);
    chk("ar_accept", 64'(ARREADY), 64'd1);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int hs0, m0, c, stall_n;
    hs0 = hs_count; m0 = mem_cnt; c = 0; stall_n = 0;
    RREADY = !v.stall;
    push_expect(v.addr, v.len, v.burst);
    drive_ar(v.addr, v.len, v.burst);
    while (hs_count - hs0 < v.exp_beats && c < 20 * v.exp_beats + 20) begin
      @(posedge ACLK); #1;
      c++;
      if (v.stall) begin
        if (RVALID) begin
          if (stall_n < 2) begin RREADY = 1'b0; stall_n++; end
          else begin RREADY = 1'b1; stall_n = 0; end
        end else RREADY = 1'b0;
      end
    end
    RREADY = 1'b0;
    chk("beats", 64'(hs_count - hs0), 64'(v.exp_beats));
    chk("mem_fetches", 64'(mem_cnt - m0), 64'(v.exp_mem));
    if (v.exp_mem != 0) chk("last_mem_addr", 64'(last_mem_addr), 64'(v.exp_last));
    chk("arready_after_last", 64'(ARREADY), 64'd1);
    chk("sb_empty", 64'(exp_beats.size() + exp_addrs.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c, hs0, stray;
    vecs[0] = '{32'h8000_0008, 8'd0, 2'b01, 1'b0, 1, 1, 32'h8000_0008};
    vecs[1] = '{32'h8000_0000, 8'd3, 2'b01, 1'b1, 4, 4, 32'h8000_0018};
    vecs[2] = '{32'h8000_0104, 8'd2, 2'b00, 1'b0, 3, 3, 32'h8000_0100};
    vecs[3] = '{32'h8000_0040, 8'd1, 2'b10, 1'b0, 2, 0, 32'h0};
    vecs[4] = '{32'h0000_1000, 8'd2, 2'b11, 1'b1, 3, 0, 32'h0};
    vecs[5] = '{32'h8000_0013, 8'd2, 2'b01, 1'b0, 3, 3, 32'h8000_0020};
    vecs[6] = '{32'hFFFF_FFF8, 8'd1, 2'b01, 1'b0, 2, 2, 32'h0000_0000};

    ARESETn = 1'b0; ARVALID = 1'b0; ARADDR = '0; ARLEN = '0; ARBURST = 2'b01;
    ARPROT = 3'b000; RREADY = 1'b0;
    #1;
    chk("rst_arready", 64'(ARREADY), 64'd0);
    chk("rst_rvalid", 64'(RVALID), 64'd0);
    chk("rst_rlast", 64'(RLAST), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_rresp", 64'(RRESP), 64'd0);
    chk("rst_rdata", RDATA, 64'd0);
    repeat (3) @(posedge ACLK);
    #1 ARESETn = 1'b1;
    @(posedge ACLK); #1;
    chk("arready_after_release", 64'(ARREADY), 64'd1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // reset in the middle of an 8-beat burst
    RREADY = 1'b1;
    push_expect(32'h8000_0200, 8'd7, 2'b01);
    hs0 = hs_count;
    drive_ar(32'h8000_0200, 8'd7, 2'b01);
    c = 0;
    while (hs_count - hs0 < 2 && c < 100) begin
      @(posedge ACLK); #1;
      c++;
    end
    chk("rst_pre_beats", 64'(hs_count - hs0), 64'd2);
    ARESETn = 1'b0;
    #1;
    chk("midrst_rvalid", 64'(RVALID), 64'd0);
    chk("midrst_rlast", 64'(RLAST), 64'd0);
    chk("midrst_mem_en", 64'(mem_en), 64'd0);
    chk("midrst_arready", 64'(ARREADY), 64'd0);
    repeat (2) @(posedge ACLK);
    #1 ARESETn = 1'b1;
    @(posedge ACLK); #1;
    chk("midrst_arready_release", 64'(ARREADY), 64'd1);
    stray = 0;
    repeat (6) begin
      @(negedge ACLK);
      if (RVALID || mem_en) stray++;
    end
    chk("midrst_stray_activity", 64'(stray), 64'd0);
    @(posedge ACLK); #1;
    run_vec(vecs[0]);

    // 256-beat burst with a second request held valid throughout
    RREADY = 1'b1;
    push_expect(32'h8000_0000, 8'hFF, 2'b01);
    push_expect(32'h9000_0010, 8'd1, 2'b01);
    hs0 = hs_count;
    drive_ar(32'h8000_0000, 8'hFF, 2'b01);
    ARVALID = 1'b1; ARADDR = 32'h9000_0010; ARLEN = 8'd1; ARBURST = 2'b01;
    c = 0;
    do begin
      @(negedge ACLK);
      c++;
    end while (!ARREADY && c < 2000);
    chk("b2b_ar_accept", 64'(ARREADY), 64'd1);
    chk("max_burst_beats", 64'(hs_count - hs0), 64'd256);
    chk("max_burst_last_addr", 64'(last_mem_addr), 64'h8000_07F8);
    chk("b2b_gap_cycles", 64'(cyc - last_hs_cyc), 64'd1);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    c = 0;
    while (hs_count - hs0 < 258 && c < 100) begin
      @(posedge ACLK); #1;
      c++;
    end
    chk("b2b_total_beats", 64'(hs_count - hs0), 64'd258);
    chk("b2b_sb_empty", 64'(exp_beats.size() + exp_addrs.size()), 64'd0);
    RREADY = 1'b0;
    repeat (3) @(posedge ACLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
